// File: rtl/pg_alu_seq.sv
// Power-gated ALU with an always-on result register and its own power-sequencing FSM.
// Simple ops respond one cycle after accept; MUL/DIV respond MD_LAT cycles after accept.
//
// state | meaning
// OFF   | domain unpowered, clamped; waits for wake_req
// WAKE  | switch on, still clamped; counts PWR_UP_CYC cycles
// ON    | powered and unclamped; accepts ops, latches sleep_req
// ISO   | clamp applied for one cycle before the switch opens
module pg_alu_seq #(
    parameter int W          = 16,
    parameter int PWR_UP_CYC = 4,
    parameter int MD_LAT     = 4,
    parameter int RETAIN     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   opcode,
    output logic         rsp_valid,
    output logic [W-1:0] result,
    output logic         err,
    input  logic         wake_req,
    input  logic         sleep_req,
    output logic         pwr_en,
    output logic         iso_en,
    output logic [1:0]   pwr_state
);

    localparam int SH_W = $clog2(W);
    localparam int CW   = $clog2(PWR_UP_CYC + 1);
    localparam int MW   = $clog2(MD_LAT + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_ISO  = 2'd3
    } pstate_t;

    pstate_t        state;
    logic [CW-1:0]  wake_cnt;
    logic           sleep_pend;

    logic           busy;
    logic [MW-1:0]  md_cnt;
    logic           s1_valid;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    logic           accept;
    logic           is_md_req;
    logic           md_done;
    logic           rsp_fire;
    logic [W-1:0]   alu_res;
    logic           alu_err;

    assign req_ready = (state == ST_ON) && !busy && !sleep_pend;
    assign accept    = req_valid && req_ready;
    assign is_md_req = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign md_done   = busy && (md_cnt == '0);
    assign rsp_fire  = (s1_valid || md_done) && !iso_en;
    assign pwr_state = state;

    // Power FSM: sleep waits for any accepted or in-flight op to respond first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            pwr_en     <= 1'b0;
            iso_en     <= 1'b1;
            wake_cnt   <= '0;
            sleep_pend <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (wake_req) begin
                        state    <= ST_WAKE;
                        pwr_en   <= 1'b1;
                        iso_en   <= 1'b1;
                        wake_cnt <= CW'(PWR_UP_CYC - 1);
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == '0) begin
                        state  <= ST_ON;
                        iso_en <= 1'b0;
                    end else begin
                        wake_cnt <= wake_cnt - CW'(1);
                    end
                end
                ST_ON: begin
                    if (sleep_req) begin
                        sleep_pend <= 1'b1;
                    end
                    if ((sleep_pend || sleep_req) && !busy && !s1_valid && !accept) begin
                        state  <= ST_ISO;
                        iso_en <= 1'b1;
                    end
                end
                ST_ISO: begin
                    state      <= ST_OFF;
                    pwr_en     <= 1'b0;
                    iso_en     <= 1'b1;
                    sleep_pend <= 1'b0;
                end
                default: begin
                    state <= ST_OFF;
                end
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHL:  alu_res = a_q << b_q[SH_W-1:0];
            OP_SHR:  alu_res = a_q >> b_q[SH_W-1:0];
            OP_PASS: alu_res = a_q;
            OP_MUL:  alu_res = a_q * b_q;
            OP_DIV: begin
                if (b_q == '0) begin
                    alu_res = '1;
                    alu_err = 1'b1;
                end else begin
                    alu_res = a_q / b_q;
                end
            end
            default: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    // Operand capture, MUL/DIV latency timer and the AON result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            s1_valid  <= 1'b0;
            busy      <= 1'b0;
            md_cnt    <= '0;
            rsp_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= rsp_fire;
            if (accept) begin
                a_q      <= A;
                b_q      <= B;
                op_q     <= opcode;
                s1_valid <= !is_md_req;
                if (is_md_req) begin
                    busy   <= 1'b1;
                    md_cnt <= MW'(MD_LAT - 1);
                end
            end else begin
                s1_valid <= 1'b0;
                if (busy) begin
                    if (md_cnt == '0) begin
                        busy <= 1'b0;
                    end else begin
                        md_cnt <= md_cnt - MW'(1);
                    end
                end
            end
            if (rsp_fire) begin
                result <= alu_res;
                err    <= alu_err;
            end else if (RETAIN == 0 && state == ST_ISO) begin
                result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pg_alu_seq.sv
// Directed bench for pg_alu_seq: scoreboard of expected responses plus power-sequence checks.
// Two instances share stimulus so retained and cleared result behaviour are seen side by side.
module tb_pg_alu_seq;

    localparam int W  = 16;
    localparam int PU = 4;
    localparam int ML = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic         wake_req;
    logic         sleep_req;

    logic         rdy1, rv1, err1, pe1, ie1;
    logic [W-1:0] res1;
    logic [1:0]   ps1;
    logic         rdy0, rv0, err0, pe0, ie0;
    logic [W-1:0] res0;
    logic [1:0]   ps0;

    pg_alu_seq #(.W(W), .PWR_UP_CYC(PU), .MD_LAT(ML), .RETAIN(1)) dut_ret (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
        .A(a), .B(b), .opcode(opcode), .rsp_valid(rv1), .result(res1), .err(err1),
        .wake_req(wake_req), .sleep_req(sleep_req), .pwr_en(pe1), .iso_en(ie1),
        .pwr_state(ps1)
    );

    pg_alu_seq #(.W(W), .PWR_UP_CYC(PU), .MD_LAT(ML), .RETAIN(0)) dut_clr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
        .A(a), .B(b), .opcode(opcode), .rsp_valid(rv0), .result(res0), .err(err0),
        .wake_req(wake_req), .sleep_req(sleep_req), .pwr_en(pe0), .iso_en(ie0),
        .pwr_state(ps0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic         e;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   rsp_seen = 0;

    always @(negedge clk) begin
        exp_t t;
        if (rv1 === 1'b1) begin
            rsp_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", sb.size(), 1);
            end else begin
                t = sb.pop_front();
                chk("rsp_result", res1, t.res);
                chk("rsp_err", err1, t.e);
                chk("rsp_cycle", cyc, t.due);
                chk("rsp_valid_clr", rv0, 1);
                chk("rsp_result_clr", res0, t.res);
            end
        end
    end

    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        logic [3:0] sh;
        sh = y[3:0];
        case (op)
            4'd0: return {1'b0, x + y};
            4'd1: return {1'b0, x - y};
            4'd2: return {1'b0, x & y};
            4'd3: return {1'b0, x | y};
            4'd4: return {1'b0, x ^ y};
            4'd5: return {1'b0, x << sh};
            4'd6: return {1'b0, x >> sh};
            4'd7: return {1'b0, x};
            4'd8: return {1'b0, x * y};
            4'd9: return (y == 0) ? {1'b1, {W{1'b1}}} : {1'b0, x / y};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    // Waits (bounded) for ready, drives one request, records the expected response.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic ee);
        int   n;
        exp_t t;
        @(negedge clk);
        n = 0;
        while (rdy1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", rdy1, 1);
        req_valid = 1'b1;
        opcode    = op;
        a         = av;
        b         = bv;
        @(posedge clk);
        #1;
        t.res = er;
        t.e   = ee;
        t.due = cyc + ((op == 4'd8 || op == 4'd9) ? ML : 1);
        sb.push_back(t);
    endtask

    task automatic md_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic ee);
        issue(op, av, bv, er, ee);
        req_valid = 1'b0;
        repeat (ML) begin
            @(negedge clk);
            chk("md_ready_low", rdy1, 0);
        end
    endtask

    task automatic wake_up(input logic with_sleep);
        @(negedge clk);
        wake_req  = 1'b1;
        sleep_req = with_sleep;
        @(negedge clk);
        wake_req  = 1'b0;
        sleep_req = 1'b0;
        chk("wake_state", ps1, 1);
        chk("wake_pwr_en", pe1, 1);
        chk("wake_iso_en", ie1, 1);
        repeat (PU - 1) @(negedge clk);
        chk("wake_iso_held", ie1, 1);
        @(negedge clk);
        chk("on_iso_en", ie1, 0);
        chk("on_ready", rdy1, 1);
        chk("on_state", ps1, 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0]   m;
        logic [3:0]   rop;
        logic [W-1:0] rx, ry;
        int           seen;

        rst_n     = 1'b1;
        req_valid = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        wake_req  = 1'b0;
        sleep_req = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_state", ps1, 0);
        chk("rst_pwr_en", pe1, 0);
        chk("rst_iso_en", ie1, 1);
        chk("rst_ready", rdy1, 0);
        chk("rst_rsp_valid", rv1, 0);
        chk("rst_result", res1, 0);
        chk("rst_err", err1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // sleep in OFF has no effect
        @(negedge clk);
        sleep_req = 1'b1;
        @(negedge clk);
        sleep_req = 1'b0;
        chk("off_ignores_sleep", ps1, 0);

        wake_up(1'b0);

        // back-to-back simple ops, then a MUL accepted in the last response cycle
        issue(4'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);
        issue(4'd5, 16'h0001, 16'h0013, 16'h0008, 1'b0);
        issue(4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        md_op(4'd8, 16'h0100, 16'h0100, 16'h0000, 1'b0);
        md_op(4'd9, 16'd100, 16'd7, 16'd14, 1'b0);
        md_op(4'd9, 16'hABCD, 16'h0000, 16'hFFFF, 1'b1);
        md_op(4'd8, 16'd300, 16'd7, 16'd2100, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'd8 || rop == 4'd9) rop = 4'd13;
            rx = 16'($urandom);
            ry = 16'($urandom);
            m  = model(rop, rx, ry);
            issue(rop, rx, ry, m[W-1:0], m[W]);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        // retention: sleep and wake requested together while ON
        issue(4'd0, 16'h1000, 16'h0234, 16'h1234, 1'b0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        wake_req  = 1'b1;
        sleep_req = 1'b1;
        @(negedge clk);
        wake_req  = 1'b0;
        sleep_req = 1'b0;
        chk("iso_state", ps1, 3);
        chk("iso_iso_en", ie1, 1);
        chk("iso_pwr_en", pe1, 1);
        chk("iso_result_ret", res1, 16'h1234);
        chk("iso_result_clr", res0, 16'h1234);
        @(negedge clk);
        chk("off_state", ps1, 0);
        chk("off_pwr_en", pe1, 0);
        chk("off_result_ret", res1, 16'h1234);
        chk("off_result_clr", res0, 16'h0000);
        repeat (3) @(negedge clk);
        wake_up(1'b1);
        chk("rewake_result_ret", res1, 16'h1234);
        chk("rewake_result_clr", res0, 16'h0000);

        // sleep one cycle after a DIV accept, with a request held pending
        issue(4'd9, 16'd1000, 16'd3, 16'd333, 1'b0);
        @(negedge clk);
        sleep_req = 1'b1;
        opcode    = 4'd0;
        a         = 16'd1;
        b         = 16'd1;
        @(negedge clk);
        sleep_req = 1'b0;
        chk("sleep_pend_ready", rdy1, 0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("div_rsp_on", ps1, 2);
        chk("div_rsp_valid", rv1, 1);
        @(negedge clk);
        chk("div_then_iso", ps1, 3);
        chk("div_iso_en", ie1, 1);
        @(negedge clk);
        chk("div_then_off", ps1, 0);
        chk("div_off_ret", res1, 16'd333);
        chk("div_off_clr", res0, 16'd0);
        req_valid = 1'b0;

        // async reset two cycles into a MUL
        wake_up(1'b0);
        issue(4'd8, 16'd3, 16'd5, 16'd15, 1'b0);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_state", ps1, 0);
        chk("midrst_pwr_en", pe1, 0);
        chk("midrst_iso_en", ie1, 1);
        chk("midrst_ready", rdy1, 0);
        chk("midrst_rsp_valid", rv1, 0);
        chk("midrst_result", res1, 0);
        chk("midrst_err", err1, 0);
        sb.delete();
        seen = rsp_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (ML + 4) @(negedge clk);
        chk("no_rsp_after_reset", rsp_seen, seen);
        chk("post_reset_state", ps1, 0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pg_alu_seq.md
# pg_alu_seq

Parametrised, power-gated ALU with an always-on (AON) result register and an integrated power-sequencing FSM. It accepts operations over a valid/ready handshake and runs single-cycle logic/arithmetic ops and multi-cycle MUL/DIV. It sequences `pwr_en`/`iso_en` for the gated ALU domain on `wake_req`/`sleep_req`. Results are captured into an AON register that can either retain its value across power-down or clear on it. The block sits between the core datapath and the AON result consumer, replacing ad-hoc `pwr_en`/`iso_en` driving from outside the ALU.

## Interface
- `W`, 16: operand/result width (≥ 8).
- `PWR_UP_CYC`, 4: cycles in WAKE before isolation release (≥ 1).
- `MD_LAT`, 4: MUL/DIV latency in cycles from accept to response (≥ 2).
- `RETAIN`, 1: 1 = AON result kept through OFF; 0 = cleared on entry to OFF.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: operation request.
- `req_ready` out 1: block can accept a request this cycle.
- `A`, `B` in W: operands, sampled on accept.
- `opcode` in 4: operation, sampled on accept.
- `rsp_valid` out 1: one-cycle pulse, result/err valid.
- `result` out W: AON result register.
- `err` out 1: error flag, qualified by `rsp_valid`.
- `wake_req` in 1: pulse, request power-up.
- `sleep_req` in 1: pulse, request power-down.
- `pwr_en` out 1: power switch enable for the ALU domain.
- `iso_en` out 1: isolation enable, 1 = clamped.
- `pwr_state` out 2: 0 OFF, 1 WAKE, 2 ON, 3 ISO.

## Operation
- **Opcodes** (mod 2^W arithmetic):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical); shift amount is `B[$clog2(W)-1:0]`.
  - 7 PASS A.
  - 8 MUL: low W bits of the product.
  - 9 DIV: unsigned quotient; B=0 gives all-ones and `err`=1.
  - 10–15: illegal; result 0 and `err`=1.
- **Accept** when `req_valid && req_ready`.
- **`req_ready`** = state ON && !busy && !sleep_pend.
- **Busy** is high from a MUL/DIV accept until its response.
- **FSM**:
  - OFF (`pwr_en`=0, `iso_en`=1): `wake_req` → WAKE. `sleep_req` is ignored.
  - WAKE (`pwr_en`=1, `iso_en`=1): counts PWR_UP_CYC cycles → ON. Requests are ignored.
  - ON (`pwr_en`=1, `iso_en`=0): `sleep_req` sets `sleep_pend`. When `sleep_pend` && !busy → ISO. `wake_req` is ignored.
  - ISO (`pwr_en`=1, `iso_en`=1): one cycle → OFF. Clears `sleep_pend`.
- **Sleep during MUL/DIV**: the in-flight op completes and responds, then the FSM enters ISO. No new accepts are allowed once `sleep_pend`=1.
- **AON result register**:
  - Written only on a response.
  - Never written while `iso_en`=1.
  - Holds its value between responses.
  - RETAIN=0: cleared to 0 on the OFF-entry cycle.
  - RETAIN=1: unchanged through OFF/WAKE.
- **`err`** is a registered output, updated with `result`, and holds its value until the next response.

## Timing
- **Reset values**: state OFF, `pwr_en`=0, `iso_en`=1, `req_ready`=0, `rsp_valid`=0, `result`=0, `err`=0, `pwr_state`=0, counters 0, `sleep_pend`=0.
- **Simple ops**: accept at edge t; `rsp_valid`=1 and `result` updated after edge t+1.
- **MUL/DIV**: accept at edge t; response after edge t+MD_LAT. `req_ready`=0 during those cycles.
- **Back-to-back**: simple ops can be accepted every cycle (throughput 1/cycle). A MUL/DIV can be accepted in the response cycle of a simple op.
- **Wake**: `wake_req` at edge t → WAKE after t+1 → ON after t+1+PWR_UP_CYC. `req_ready` rises in the same cycle ON is entered.
- **Sleep when idle**: `sleep_req` at edge t → `sleep_pend` set, ISO after t+1, OFF after t+2.
- **`wake_req` and `sleep_req` in the same cycle**: the request that is valid for the current state applies; the other is dropped.
- **`sleep_req` in the accept cycle of a MUL/DIV**: the op is accepted and completes before ISO.
- **Async reset mid-operation**: all state returns to reset values immediately. An in-flight op is discarded with no `rsp_valid`.

## Test plan
- **Power-up**: after reset, pulse `wake_req` with PWR_UP_CYC=4. Require `iso_en` to fall exactly 5 cycles later and `req_ready`=1.
- **Simple ops**, W=16:
  - ADD 0xFFFF+0x0002 → 0x0001, `err`=0, 1-cycle latency.
  - SHL 0x0001 by B=0x0013 (amount 3) → 0x0008.
  - opcode 12 → result 0, `err`=1.
- **MUL/DIV**, MD_LAT=4:
  - MUL 0x0100×0x0100 → 0x0000.
  - DIV 100/7 → 14.
  - DIV x/0 → 0xFFFF with `err`=1.
  - Each responds 4 cycles after accept, with `req_ready`=0 in between.
- **Sleep during DIV**: `sleep_req` one cycle after accept. Require the DIV response, then ISO, then OFF. No accepts after `sleep_req`.
- **Retention**: finish ADD=0x1234, sleep, then wake. RETAIN=1 → `result` stays 0x1234 throughout. RETAIN=0 → `result` becomes 0 on OFF entry.
- **Reset mid-MUL**: assert `rst_n`=0 two cycles after accept. Require immediate reset values and no `rsp_valid` after release.
